vend_ctrl: RTL
==============

# vend_ctrl

Parametrised vending-machine controller: accumulates coin credit, validates a product purchase against a per-product price table and per-product stock counters, and returns change through a coin-by-coin ready/valid handshake. It is the sequential successor to the single-shot calculate/sell pair. It sits between the coin/keypad front end and the display encoders: `credit` and `change_amt` feed the binary-to-seven-segment path unchanged.

## Interface
- CREDIT_W, 8: width of credit, coin value, prices and change.
- NUM_PROD, 6: number of products; valid selection codes are 1..NUM_PROD, and 0 means none.
- SEL_W, 3: selection width; must satisfy 2^SEL_W > NUM_PROD.
- PRICES, {8'd30,8'd243,8'd230,8'd190,8'd150,8'd110}: packed NUM_PROD*CREDIT_W price table; the price of product i is `PRICES[i*CREDIT_W-1 -: CREDIT_W]`.
- STOCK_W, 4: width of each stock counter.
- STOCK_INIT, 5: stock loaded at reset and on restock.
- CHANGE_UNIT, 10: largest amount returned per change beat; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coin_valid  in  1  coin present this cycle.
- coin_value  in  CREDIT_W  value of the coin.
- buy_valid  in  1  purchase request.
- buy_sel  in  SEL_W  requested product.
- refund  in  1  return all credit.
- restock  in  1  reload every stock counter to STOCK_INIT.
- change_ready  in  1  dispenser accepts a change beat.
- credit  out  CREDIT_W  current credit, or the remaining change while in CHANGE.
- vend_valid  out  1  one-cycle pulse when a sale succeeds.
- vend_type  out  SEL_W  product sold; 0 when vend_valid is low.
- deny  out  1  one-cycle pulse when a purchase is rejected.
- deny_code  out  2  01 insufficient credit, 10 sold out, 11 invalid selection; 00 when deny is low.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- change_valid  out  1  change beat offered.
- change_amt  out  CREDIT_W  value of the offered beat.
- sold_out  out  NUM_PROD  bit i-1 is set when product i has zero stock.
- busy  out  1  high while in CHANGE.

## Operation
- The FSM has two states, IDLE and CHANGE. Reset enters IDLE.
- IDLE priority, evaluated each cycle: refund, then buy, then coin. Only one action is taken per cycle.
- If a coin arrives in the same cycle as a refund or buy, the coin is dropped and coin_reject pulses.
- Coin: when credit + coin_value ≤ 2^CREDIT_W−1, it is added to credit. Otherwise credit is unchanged and coin_reject pulses. The add is computed at CREDIT_W+1 bits; no wrap-around is allowed.
- Buy checks run in this order:
  - sel = 0 or sel > NUM_PROD → deny code 11.
  - stock = 0 → deny code 10.
  - credit < price → deny code 01.
  - Credit is unchanged on any deny.
- Buy success:
  - vend_valid=1 and vend_type=sel; the stock counter decrements.
  - remaining = credit − price.
  - If remaining > 0: credit ← remaining, go to CHANGE. Otherwise credit ← 0 and stay in IDLE.
- Refund: if credit > 0, go to CHANGE with remaining = credit. If credit = 0, nothing happens and no beat is produced.
- CHANGE:
  - change_valid=1 and change_amt = min(credit, CHANGE_UNIT).
  - On change_valid & change_ready, credit −= change_amt.
  - When credit reaches 0, return to IDLE, with change_valid low in the next cycle.
  - change_amt and change_valid stay stable while change_ready is low.
- In CHANGE, coins are rejected with coin_reject, and buy, refund and restock are ignored: no deny, no state change.
- Restock in IDLE sets all stock to STOCK_INIT. If restock and buy occur in the same cycle, restock takes effect and the buy is evaluated against the pre-restock stock.

## Timing
- All outputs are registered and change only on the rising edge of clk or on reset.
- A response appears the cycle after the request: vend_valid, deny and coin_reject are each high for exactly one cycle.
- A CHANGE entry asserts change_valid the cycle after the buy or refund. Each beat takes at least one cycle; with change_ready held at 1, the change takes ceil(remaining/CHANGE_UNIT) cycles.
- sold_out reflects stock one cycle after the decrement or restock.
- Reset values: credit 0, vend_valid 0, vend_type 0, deny 0, deny_code 0, coin_reject 0, change_valid 0, change_amt 0, busy 0, all stock = STOCK_INIT, sold_out 0, state IDLE.
- Reset asserted mid-CHANGE aborts immediately. The remaining change is discarded, not returned.

## Test plan
- Coins 100 then 50, then buy sel 2 → vend_valid pulse with type 2, credit 0, no change_valid, stock[2] goes 5→4.
- Coin 200, buy sel 1 → vend type 1, then 9 beats of change_amt 10. Holding change_ready low for 3 cycles mid-sequence keeps amt and valid stable; busy drops after the last beat.
- Credit 250, coin 10 → coin_reject, credit stays 250. Then refund → beats of 10×25, then IDLE.
- Credit 100: buy sel 3 → deny 01; buy sel 7 → deny 11; buy sel 0 → deny 11. Credit stays 100 throughout.
- Five purchases of sel 6 (price 30, coin 30 each) → stock 0 and sold_out[5]=1. Sixth purchase → deny 10. Restock → sold_out 0, next purchase succeeds.
- Refund of 25 → beats 10, 10, 5. rst_n pulsed low during the second beat → all outputs at reset values immediately, IDLE, stock restored to 5.

Source files
------------

// File: rtl/vend_ctrl.sv
// vend_ctrl: sequential vending-machine controller.
// Accumulates coin credit, validates purchases against a price table and
// per-product stock counters, and pays out change one beat at a time over a
// ready/valid handshake.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   coin_valid, coin_value     coin insertion
//   buy_valid, buy_sel         purchase request (sel 1..NUM_PROD, 0 = none)
//   refund                     return all credit as change
//   restock                    reload every stock counter to STOCK_INIT
//   change_ready               dispenser accepts the offered change beat
//   credit                     current credit / remaining change in CHANGE
//   vend_valid, vend_type      one-cycle sale pulse and product sold
//   deny, deny_code            one-cycle reject pulse (01 credit, 10 stock, 11 sel)
//   coin_reject                one-cycle coin-refused pulse
//   change_valid, change_amt   change beat offered and its value
//   sold_out                   bit i-1 set when product i has zero stock
//   busy                       high while paying out change
module vend_ctrl #(
  parameter int CREDIT_W    = 8,
  parameter int NUM_PROD    = 6,
  parameter int SEL_W       = 3,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES =
    {8'd30, 8'd243, 8'd230, 8'd190, 8'd150, 8'd110},
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 5,
  parameter int CHANGE_UNIT = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                buy_valid,
  input  logic [SEL_W-1:0]    buy_sel,
  input  logic                refund,
  input  logic                restock,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_type,
  output logic                deny,
  output logic [1:0]          deny_code,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [NUM_PROD-1:0] sold_out,
  output logic                busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_CHANGE = 1'b1;
  localparam logic [CREDIT_W-1:0] UNIT  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [STOCK_W-1:0]  SINIT = STOCK_W'(STOCK_INIT);

  logic [0:0]                       r_state;
  logic [CREDIT_W-1:0]              r_credit;
  logic                             r_vend_valid;
  logic [SEL_W-1:0]                 r_vend_type;
  logic                             r_deny;
  logic [1:0]                       r_deny_code;
  logic                             r_coin_reject;
  logic                             r_chg_valid;
  logic [CREDIT_W-1:0]              r_chg_amt;
  logic                             r_busy;
  logic [NUM_PROD-1:0][STOCK_W-1:0] r_stock;
  logic [NUM_PROD-1:0]              r_sold_out;

  logic                w_sel_bad;
  logic [CREDIT_W-1:0] w_price;
  logic [STOCK_W-1:0]  w_stock;
  logic [CREDIT_W:0]   w_coin_sum;
  logic [CREDIT_W-1:0] w_remain;
  logic [CREDIT_W-1:0] w_chg_left;

  function automatic logic [CREDIT_W-1:0] f_beat(input logic [CREDIT_W-1:0] v);
    return (v < UNIT) ? v : UNIT;
  endfunction

  assign w_sel_bad  = (buy_sel == '0) || (buy_sel > SEL_W'(NUM_PROD));
  // Extra carry bit detects overflow instead of wrapping.
  assign w_coin_sum = {1'b0, r_credit} + {1'b0, coin_value};
  assign w_remain   = r_credit - w_price;
  assign w_chg_left = r_credit - r_chg_amt;

  // Price/stock lookup by compare rather than index, so an out-of-range
  // selection never addresses past the tables.
  always_comb begin
    w_price = '0;
    w_stock = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (buy_sel == SEL_W'(i + 1)) begin
        w_price = PRICES[i*CREDIT_W +: CREDIT_W];
        w_stock = r_stock[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_vend_valid  <= 1'b0;
      r_vend_type   <= '0;
      r_deny        <= 1'b0;
      r_deny_code   <= 2'b00;
      r_coin_reject <= 1'b0;
      r_chg_valid   <= 1'b0;
      r_chg_amt     <= '0;
      r_busy        <= 1'b0;
      r_sold_out    <= '0;
      for (int i = 0; i < NUM_PROD; i++) r_stock[i] <= SINIT;
    end else begin
      r_vend_valid  <= 1'b0;
      r_vend_type   <= '0;
      r_deny        <= 1'b0;
      r_deny_code   <= 2'b00;
      r_coin_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (restock) begin
            r_sold_out <= '0;
            for (int i = 0; i < NUM_PROD; i++) r_stock[i] <= SINIT;
          end
          if (refund) begin
            r_coin_reject <= coin_valid;
            if (r_credit != '0) begin
              r_state     <= S_CHANGE;
              r_busy      <= 1'b1;
              r_chg_valid <= 1'b1;
              r_chg_amt   <= f_beat(r_credit);
            end
          end else if (buy_valid) begin
            r_coin_reject <= coin_valid;
            if (w_sel_bad) begin
              r_deny <= 1'b1; r_deny_code <= 2'b11;
            end else if (w_stock == '0) begin
              r_deny <= 1'b1; r_deny_code <= 2'b10;
            end else if (r_credit < w_price) begin
              r_deny <= 1'b1; r_deny_code <= 2'b01;
            end else begin
              r_vend_valid <= 1'b1;
              r_vend_type  <= buy_sel;
              // A simultaneous restock overrides the decrement.
              if (!restock) begin
                for (int i = 0; i < NUM_PROD; i++) begin
                  if (buy_sel == SEL_W'(i + 1)) begin
                    r_stock[i]    <= r_stock[i] - STOCK_W'(1);
                    r_sold_out[i] <= (r_stock[i] == STOCK_W'(1));
                  end
                end
              end
              r_credit <= w_remain;
              if (w_remain != '0) begin
                r_state     <= S_CHANGE;
                r_busy      <= 1'b1;
                r_chg_valid <= 1'b1;
                r_chg_amt   <= f_beat(w_remain);
              end
            end
          end else if (coin_valid) begin
            if (w_coin_sum[CREDIT_W]) r_coin_reject <= 1'b1;
            else                      r_credit <= w_coin_sum[CREDIT_W-1:0];
          end
        end
        default: begin
          // Paying out: only the handshake matters, coins bounce.
          r_coin_reject <= coin_valid;
          if (change_ready) begin
            r_credit <= w_chg_left;
            if (w_chg_left == '0) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_chg_valid <= 1'b0;
              r_chg_amt   <= '0;
            end else begin
              r_chg_amt <= f_beat(w_chg_left);
            end
          end
        end
      endcase
    end
  end

  assign credit       = r_credit;
  assign vend_valid   = r_vend_valid;
  assign vend_type    = r_vend_type;
  assign deny         = r_deny;
  assign deny_code    = r_deny_code;
  assign coin_reject  = r_coin_reject;
  assign change_valid = r_chg_valid;
  assign change_amt   = r_chg_amt;
  assign sold_out     = r_sold_out;
  assign busy         = r_busy;

endmodule
